// File: rtl/branch_rs_scheduler.sv
// Branch reservation station and issue scheduler.
//
// branch_rs_pkg  : comparison function encoding shared with dispatch.
// branch_alu     : combinational branch comparator (taken / not taken).
// branch_rs_scheduler:
//   clk_in, rst_in (sync, active-low), flush_in       - clock, reset, flush
//   disp_*                                             - dispatch request with
//                                                        per-source rdy/tag/val
//   disp_ready_out                                     - a free entry exists
//   cdb_valid_in / cdb_tag_in / cdb_data_in            - result broadcast snoop
//   res_valid_out / res_rob_tag_out / res_taken_out /
//   res_target_out                                     - registered resolve
//   occupancy_out                                      - valid entry count
// Holds up to DEPTH branch ops, wakes waiting operands from the CDB and
// issues the oldest ready entry into the comparator each cycle.

package branch_rs_pkg;
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NEQ = 3'd1,
        BR_LT  = 3'd2,
        BR_LTU = 3'd3,
        BR_GE  = 3'd4,
        BR_GEU = 3'd5,
        BR_DBR = 3'd6
    } br_func_t;
endpackage

module branch_alu
    import branch_rs_pkg::*;
(
    input  br_func_t    func,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        taken
);
    always_comb begin
        taken = 1'b0;
        case (func)
            BR_EQ:   taken = (src1 == src2);
            BR_NEQ:  taken = (src1 != src2);
            BR_LT:   taken = ($signed(src1) <  $signed(src2));
            BR_LTU:  taken = (src1 <  src2);
            BR_GE:   taken = ($signed(src1) >= $signed(src2));
            BR_GEU:  taken = (src1 >= src2);
            default: taken = 1'b0;   // Dbr and unused encodings never redirect
        endcase
    end
endmodule

module branch_rs_scheduler
    import branch_rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       disp_valid_in,
    output logic                       disp_ready_out,
    input  br_func_t                   disp_func_in,
    input  logic [TAG_W-1:0]           disp_rob_tag_in,
    input  logic [31:0]                disp_target_in,
    input  logic                       disp_src1_rdy_in,
    input  logic                       disp_src2_rdy_in,
    input  logic [TAG_W-1:0]           disp_src1_tag_in,
    input  logic [TAG_W-1:0]           disp_src2_tag_in,
    input  logic [31:0]                disp_src1_val_in,
    input  logic [31:0]                disp_src2_val_in,
    input  logic                       cdb_valid_in,
    input  logic [TAG_W-1:0]           cdb_tag_in,
    input  logic [31:0]                cdb_data_in,
    output logic                       res_valid_out,
    output logic [TAG_W-1:0]           res_rob_tag_out,
    output logic                       res_taken_out,
    output logic [31:0]                res_target_out,
    output logic [$clog2(DEPTH):0]     occupancy_out
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry storage. Kept in flops: every entry is compared against the CDB
    // tag in parallel, so a RAM would not fit.
    logic [DEPTH-1:0]  valid_reg;
    br_func_t          func_reg    [DEPTH];
    logic [TAG_W-1:0]  rob_tag_reg [DEPTH];
    logic [31:0]       target_reg  [DEPTH];
    logic [DEPTH-1:0]  s1_rdy_reg;
    logic [DEPTH-1:0]  s2_rdy_reg;
    logic [TAG_W-1:0]  s1_tag_reg  [DEPTH];
    logic [TAG_W-1:0]  s2_tag_reg  [DEPTH];
    logic [31:0]       s1_val_reg  [DEPTH];
    logic [31:0]       s2_val_reg  [DEPTH];
    // Age rank: 0 = oldest; ranks of valid entries are always 0..occ-1.
    logic [IDX_W-1:0]  age_reg     [DEPTH];

    logic [CNT_W-1:0]  occ_reg;
    logic              res_valid_reg;
    logic [TAG_W-1:0]  res_rob_tag_reg;
    logic              res_taken_reg;
    logic [31:0]       res_target_reg;

    logic [DEPTH-1:0]  cand;
    logic [DEPTH-1:0]  wake1;
    logic [DEPTH-1:0]  wake2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign cand[gi]  = valid_reg[gi] & s1_rdy_reg[gi] & s2_rdy_reg[gi];
            assign wake1[gi] = valid_reg[gi] & ~s1_rdy_reg[gi] & cdb_valid_in &
                               (s1_tag_reg[gi] == cdb_tag_in);
            assign wake2[gi] = valid_reg[gi] & ~s2_rdy_reg[gi] & cdb_valid_in &
                               (s2_tag_reg[gi] == cdb_tag_in);
        end
    endgenerate

    // Oldest ready entry (smallest age rank).
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  sel_age;
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && (!sel_found || age_reg[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_reg[i];
            end
        end
    end

    // Lowest-index free slot, from registered valid bits only.
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_reg[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    logic alu_taken;
    branch_alu u_branch_alu (
        .func  (func_reg[sel_idx]),
        .src1  (s1_val_reg[sel_idx]),
        .src2  (s2_val_reg[sel_idx]),
        .taken (alu_taken)
    );

    logic              disp_fire;
    logic              byp1;
    logic              byp2;
    logic [IDX_W-1:0]  new_age;
    assign disp_ready_out = (occ_reg < DEPTH_C);
    assign disp_fire      = disp_valid_in & disp_ready_out & ~flush_in;
    assign byp1 = ~disp_src1_rdy_in & cdb_valid_in & (disp_src1_tag_in == cdb_tag_in);
    assign byp2 = ~disp_src2_rdy_in & cdb_valid_in & (disp_src2_tag_in == cdb_tag_in);
    // The newcomer ranks behind every entry that survives this edge.
    assign new_age = IDX_W'(occ_reg - CNT_W'(sel_found));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            occ_reg         <= '0;
            res_valid_reg   <= 1'b0;
            res_rob_tag_reg <= '0;
            res_taken_reg   <= 1'b0;
            res_target_reg  <= '0;
            valid_reg       <= '0;
            s1_rdy_reg      <= '0;
            s2_rdy_reg      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_reg[i] <= '0;
            end
        end else if (flush_in) begin
            occ_reg       <= '0;
            res_valid_reg <= 1'b0;
            valid_reg     <= '0;
        end else begin
            res_valid_reg <= sel_found;
            if (sel_found) begin
                res_rob_tag_reg <= rob_tag_reg[sel_idx];
                res_taken_reg   <= alu_taken;
                res_target_reg  <= target_reg[sel_idx];
            end
            occ_reg <= occ_reg + CNT_W'(disp_fire) - CNT_W'(sel_found);
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_found && sel_idx == IDX_W'(i)) begin
                    valid_reg[i] <= 1'b0;
                end else if (valid_reg[i]) begin
                    if (wake1[i]) begin
                        s1_rdy_reg[i] <= 1'b1;
                        s1_val_reg[i] <= cdb_data_in;
                    end
                    if (wake2[i]) begin
                        s2_rdy_reg[i] <= 1'b1;
                        s2_val_reg[i] <= cdb_data_in;
                    end
                    if (sel_found && age_reg[i] > sel_age) begin
                        age_reg[i] <= age_reg[i] - 1'b1;
                    end
                end else if (disp_fire && free_idx == IDX_W'(i)) begin
                    valid_reg[i]   <= 1'b1;
                    func_reg[i]    <= disp_func_in;
                    rob_tag_reg[i] <= disp_rob_tag_in;
                    target_reg[i]  <= disp_target_in;
                    age_reg[i]     <= new_age;
                    s1_tag_reg[i]  <= disp_src1_tag_in;
                    s2_tag_reg[i]  <= disp_src2_tag_in;
                    s1_rdy_reg[i]  <= disp_src1_rdy_in | byp1;
                    s2_rdy_reg[i]  <= disp_src2_rdy_in | byp2;
                    s1_val_reg[i]  <= disp_src1_rdy_in ? disp_src1_val_in : cdb_data_in;
                    s2_val_reg[i]  <= disp_src2_rdy_in ? disp_src2_val_in : cdb_data_in;
                end
            end
        end
    end

    assign res_valid_out   = res_valid_reg;
    assign res_rob_tag_out = res_rob_tag_reg;
    assign res_taken_out   = res_taken_reg;
    assign res_target_out  = res_target_reg;
    assign occupancy_out   = occ_reg;

endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Self-checking bench for branch_rs_scheduler: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model
// of the station kept in oldest-first order.
module tb_branch_rs_scheduler;
    import branch_rs_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              flush_in;
    logic              disp_valid_in;
    logic              disp_ready_out;
    br_func_t          disp_func_in;
    logic [TAG_W-1:0]  disp_rob_tag_in;
    logic [31:0]       disp_target_in;
    logic              disp_src1_rdy_in, disp_src2_rdy_in;
    logic [TAG_W-1:0]  disp_src1_tag_in, disp_src2_tag_in;
    logic [31:0]       disp_src1_val_in, disp_src2_val_in;
    logic              cdb_valid_in;
    logic [TAG_W-1:0]  cdb_tag_in;
    logic [31:0]       cdb_data_in;
    logic              res_valid_out;
    logic [TAG_W-1:0]  res_rob_tag_out;
    logic              res_taken_out;
    logic [31:0]       res_target_out;
    logic [$clog2(DEPTH):0] occupancy_out;

    branch_rs_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .flush_in         (flush_in),
        .disp_valid_in    (disp_valid_in),
        .disp_ready_out   (disp_ready_out),
        .disp_func_in     (disp_func_in),
        .disp_rob_tag_in  (disp_rob_tag_in),
        .disp_target_in   (disp_target_in),
        .disp_src1_rdy_in (disp_src1_rdy_in),
        .disp_src2_rdy_in (disp_src2_rdy_in),
        .disp_src1_tag_in (disp_src1_tag_in),
        .disp_src2_tag_in (disp_src2_tag_in),
        .disp_src1_val_in (disp_src1_val_in),
        .disp_src2_val_in (disp_src2_val_in),
        .cdb_valid_in     (cdb_valid_in),
        .cdb_tag_in       (cdb_tag_in),
        .cdb_data_in      (cdb_data_in),
        .res_valid_out    (res_valid_out),
        .res_rob_tag_out  (res_rob_tag_out),
        .res_taken_out    (res_taken_out),
        .res_target_out   (res_target_out),
        .occupancy_out    (occupancy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]       func;
        logic [TAG_W-1:0] rob;
        logic [31:0]      target;
        bit               r1, r2;
        logic [TAG_W-1:0] t1, t2;
        logic [31:0]      v1, v2;
    } ent_t;

    ent_t        q[$];          // model: station contents, oldest first
    logic        exp_valid = 1'b0;
    logic [TAG_W-1:0] exp_tag = '0;
    logic        exp_taken = 1'b0;
    logic [31:0] exp_target = '0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, obs, exp, $time);
    endtask

    // Signed order expressed by flipping the sign bit and comparing unsigned.
    function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa, sb;
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa < sb;
            3'd3:    return a < b;
            3'd4:    return !(sa < sb);
            3'd5:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock with the current inputs, clock the DUT
    // and compare every output.
    task automatic step();
        int   pre;
        int   hit;
        ent_t e;
        if (!rst_in) begin
            q.delete();
            exp_valid = 0; exp_tag = '0; exp_taken = 0; exp_target = '0;
        end else if (flush_in) begin
            q.delete();
            exp_valid = 0;
        end else begin
            pre = q.size();
            hit = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].r1 && q[i].r2) begin hit = i; break; end
            end
            if (hit >= 0) begin
                exp_valid  = 1;
                exp_tag    = q[hit].rob;
                exp_taken  = ref_taken(q[hit].func, q[hit].v1, q[hit].v2);
                exp_target = q[hit].target;
                q.delete(hit);
            end else begin
                exp_valid = 0;
            end
            if (cdb_valid_in) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (!q[i].r1 && q[i].t1 == cdb_tag_in) begin q[i].r1 = 1; q[i].v1 = cdb_data_in; end
                    if (!q[i].r2 && q[i].t2 == cdb_tag_in) begin q[i].r2 = 1; q[i].v2 = cdb_data_in; end
                end
            end
            if (disp_valid_in && pre < DEPTH) begin
                e.func = disp_func_in; e.rob = disp_rob_tag_in; e.target = disp_target_in;
                e.t1 = disp_src1_tag_in; e.t2 = disp_src2_tag_in;
                e.r1 = disp_src1_rdy_in; e.v1 = disp_src1_val_in;
                e.r2 = disp_src2_rdy_in; e.v2 = disp_src2_val_in;
                if (!e.r1 && cdb_valid_in && e.t1 == cdb_tag_in) begin e.r1 = 1; e.v1 = cdb_data_in; end
                if (!e.r2 && cdb_valid_in && e.t2 == cdb_tag_in) begin e.r2 = 1; e.v2 = cdb_data_in; end
                q.push_back(e);
            end
        end
        @(posedge clk_in); #1;
        check_val("res_valid", 32'(res_valid_out), 32'(exp_valid));
        check_val("res_rob_tag", 32'(res_rob_tag_out), 32'(exp_tag));
        check_val("res_taken", 32'(res_taken_out), 32'(exp_taken));
        check_val("res_target", res_target_out, exp_target);
        check_val("occupancy", 32'(occupancy_out), 32'(q.size()));
        check_val("disp_ready", 32'(disp_ready_out), 32'(q.size() < DEPTH));
    endtask

    task automatic idle();
        rst_in = 1; flush_in = 0; disp_valid_in = 0; cdb_valid_in = 0;
    endtask

    task automatic disp(input logic [2:0] f, input logic [TAG_W-1:0] rob, input logic [31:0] tgt,
                        input bit r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                        input bit r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
        disp_valid_in = 1; disp_func_in = br_func_t'(f); disp_rob_tag_in = rob; disp_target_in = tgt;
        disp_src1_rdy_in = r1; disp_src1_tag_in = t1; disp_src1_val_in = v1;
        disp_src2_rdy_in = r2; disp_src2_tag_in = t2; disp_src2_val_in = v2;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
        cdb_valid_in = 1; cdb_tag_in = t; cdb_data_in = d;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [2:0] sign_funcs [4];
    logic       sign_exp   [4];

    initial begin
        idle();
        disp(3'd0, '0, '0, 1, '0, '0, 1, '0, '0);
        disp_valid_in = 0;
        cdb_tag_in = '0; cdb_data_in = '0;

        // Reset state
        rst_in = 0; step(); step();
        check_val("reset_ready", 32'(disp_ready_out), 32'd1);
        idle();

        // Ready dispatch: Eq 5 vs 5, resolves one edge after dispatch
        disp(3'd0, 4'd3, 32'h100, 1, '0, 32'd5, 1, '0, 32'd5); step();
        idle(); step();
        $display("ready dispatch: valid=%0d tag=%0d taken=%0d target=%h occ=%0d",
                 res_valid_out, res_rob_tag_out, res_taken_out, res_target_out, occupancy_out);
        check_val("eq_valid", 32'(res_valid_out), 32'd1);
        check_val("eq_taken", 32'(res_taken_out), 32'd1);
        check_val("eq_target", res_target_out, 32'h100);

        // Signed vs unsigned: 0xFFFFFFFF vs 1
        sign_funcs = '{3'd2, 3'd3, 3'd5, 3'd6};
        sign_exp   = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            disp(sign_funcs[k], 4'd4, 32'h200, 1, '0, 32'hFFFF_FFFF, 1, '0, 32'd1); step();
            idle(); step();
            $display("func %0d: taken=%0d", sign_funcs[k], res_taken_out);
            check_val("sign_taken", 32'(res_taken_out), 32'(sign_exp[k]));
        end
        // Undefined encoding never taken, even with equal operands
        disp(3'd7, 4'd4, 32'h200, 1, '0, 32'd9, 1, '0, 32'd9); step();
        idle(); step();
        check_val("undef_taken", 32'(res_taken_out), 32'd0);

        // Wakeup ordering: A waits on tag 7, B ready; B resolves first
        disp(3'd0, 4'd1, 32'h400, 0, 4'd7, '0, 1, '0, 32'h10); step();
        disp(3'd1, 4'd2, 32'h500, 1, '0, 32'd1, 1, '0, 32'd2); step();
        idle(); step();
        check_val("wake_b_tag", 32'(res_rob_tag_out), 32'd2);
        step();
        check_val("wake_idle", 32'(res_valid_out), 32'd0);
        cdb(4'd7, 32'h10); step();
        idle(); step();
        $display("wakeup: valid=%0d tag=%0d taken=%0d", res_valid_out, res_rob_tag_out, res_taken_out);
        check_val("wake_a_tag", 32'(res_rob_tag_out), 32'd1);
        check_val("wake_a_taken", 32'(res_taken_out), 32'd1);

        // Age priority: fill with entries waiting on tag 9
        for (int k = 0; k < DEPTH; k++) begin
            disp(3'(k), 4'(10 + k), 32'h600 + 32'(k), 0, 4'd9, '0, 0, 4'd9, '0); step();
        end
        check_val("full_ready", 32'(disp_ready_out), 32'd0);
        disp(3'd0, 4'd15, 32'h700, 1, '0, '0, 1, '0, '0); step();   // rejected while full
        check_val("full_occ", 32'(occupancy_out), 32'd4);
        idle(); cdb(4'd9, 32'h33); step();
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            step();
            $display("age drain %0d: tag=%0d ready=%0d", k, res_rob_tag_out, disp_ready_out);
            check_val("age_order", 32'(res_rob_tag_out), 32'(10 + k));
            if (k == 0) check_val("age_ready", 32'(disp_ready_out), 32'd1);
        end

        // Same-cycle bypass: Ltu 0x1F < bypassed 0x20
        disp(3'd3, 4'd6, 32'h300, 1, '0, 32'h1F, 0, 4'd5, '0); cdb(4'd5, 32'h20); step();
        idle(); step();
        check_val("byp_taken", 32'(res_taken_out), 32'd1);

        // Flush with pending entries and a ready candidate
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) begin
                disp(3'd0, 4'(k + 1), 32'h800, 0, 4'd14, '0, 1, '0, '0); step();
            end
            disp(3'd0, 4'd8, 32'h900, 1, '0, '0, 1, '0, '0); step();
            idle();
            if (pass == 0) flush_in = 1; else rst_in = 0;
            step();
            idle();
            check_val("flush_occ", 32'(occupancy_out), 32'd0);
            check_val("flush_valid", 32'(res_valid_out), 32'd0);
            check_val("flush_tag", 32'(res_rob_tag_out), pass == 0 ? 32'd6 : 32'd0);
            cdb(4'd14, 32'h0); step();
            idle(); step(); step();
            check_val("flush_quiet", 32'(res_valid_out), 32'd0);
            $display("flush pass %0d: occ=%0d tag=%0d", pass, occupancy_out, res_rob_tag_out);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_in   = ($urandom_range(0, 199) != 0);
            flush_in = ($urandom_range(0, 99) == 0);
            disp_valid_in    = ($urandom_range(0, 9) < 6);
            disp_func_in     = br_func_t'(3'($urandom_range(0, 7)));
            disp_rob_tag_in  = TAG_W'($urandom);
            disp_target_in   = $urandom;
            disp_src1_rdy_in = $urandom_range(0, 1) == 1;
            disp_src2_rdy_in = $urandom_range(0, 1) == 1;
            disp_src1_tag_in = TAG_W'($urandom_range(0, 7));
            disp_src2_tag_in = TAG_W'($urandom_range(0, 7));
            disp_src1_val_in = rand_val();
            disp_src2_val_in = rand_val();
            cdb_valid_in     = ($urandom_range(0, 9) < 4);
            cdb_tag_in       = TAG_W'($urandom_range(0, 7));
            cdb_data_in      = rand_val();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_rs_scheduler.md
Name: branch_rs_scheduler

Overview:
- Reservation station and issue scheduler for the branch comparison unit in the out-of-order core.
- Accepts dispatched branch ops whose operands may still be pending, snoops the common data bus (CDB) for missing operands, and selects the oldest ready entry each cycle.
- Drives the selected entry into one internal branchAlu instance and registers the resolved outcome for the ROB / fetch redirect logic.

Parameters:
- DEPTH, 4, number of station entries (power of two, 2..16).
- TAG_W, 4, ROB/physical tag width used for operand and destination tags.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous, active-low reset
- flush_in  input  1  mispredict/pipeline flush; drops all entries
- disp_valid_in  input  1  dispatch request
- disp_ready_out  output  1  station can accept
- disp_func_in  input  BrFunc  comparison function (Eq, Neq, Lt, Ltu, Ge, Geu, Dbr)
- disp_rob_tag_in  input  TAG_W  ROB tag of the branch
- disp_target_in  input  32  precomputed branch target
- disp_src1_rdy_in / disp_src2_rdy_in  input  1  operand already available
- disp_src1_tag_in / disp_src2_tag_in  input  TAG_W  producer tag if not ready
- disp_src1_val_in / disp_src2_val_in  input  32  operand value if ready
- cdb_valid_in  input  1  CDB broadcast valid
- cdb_tag_in  input  TAG_W  broadcast tag
- cdb_data_in  input  32  broadcast value
- res_valid_out  output  1  resolved branch valid (1-cycle pulse)
- res_rob_tag_out  output  TAG_W  ROB tag of resolved branch
- res_taken_out  output  1  branchAlu result
- res_target_out  output  32  target of resolved branch
- occupancy_out  output  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (rst_in=0 at a rising edge): all entries invalid; occupancy_out=0; res_valid_out=0, res_rob_tag_out=0, res_taken_out=0, res_target_out=0; disp_ready_out=1 after reset.
- Entry fields: valid, func, rob_tag, target, per-source rdy/tag/val, and an age rank.
- disp_ready_out = (occupancy < DEPTH). This is registered state only. A slot freed by issue in the same cycle is not reusable until the next cycle.
- Dispatch:
  - Accepted when disp_valid_in && disp_ready_out && !flush_in.
  - Writes the lowest-index free entry and gives it the youngest age.
  - Bypass: if a source is not ready and cdb_valid_in with cdb_tag_in equal to its tag in the same cycle, the source is stored ready with cdb_data_in.
- Wakeup: every valid entry with a non-ready source whose tag matches a valid CDB broadcast captures cdb_data_in and sets rdy at that edge. Both sources of one entry may wake on the same broadcast.
- Select (combinational, each cycle):
  - Candidates are valid entries with both sources ready.
  - Picks the oldest by age rank. Ties are impossible; ranks are unique.
  - A wakeup takes effect for select one cycle after the broadcast.
- Issue:
  - The selected entry's values and func drive branchAlu.
  - At the edge: res_valid_out<=1 with rob_tag, taken, target of that entry; the entry is freed; ages of younger entries are compacted.
  - With no candidate: res_valid_out<=0; other res_* hold their values.
- Latency:
  - Dispatch with both ready in cycle N: res_valid_out=1 in cycle N+1.
  - CDB wakeup in cycle M, no older competitor: res_valid_out=1 in cycle M+1.
  - Throughput: one resolve per cycle.
- Dbr or any undefined func resolves with res_taken_out=0.
- Signed compares (Lt, Ge) are two's complement; Ltu and Geu are unsigned 32-bit.
- Occupancy: +1 on dispatch, −1 on issue, unchanged if both happen in the same cycle.
- Flush has priority over dispatch, wakeup and issue. At the edge, all entries are invalidated, occupancy=0 and res_valid_out<=0; res_* payloads hold. An issue selected in the flush cycle is discarded.
- Reset mid-operation has the same effect as flush, plus the res_* payloads clear to 0.
- CDB tags matching no entry are ignored. A tag match on an already-ready source has no effect.

Test Plan:
- Ready dispatch: Eq, src1=src2=0x0000_0005, rob_tag=3, target=0x100, dispatch at cycle N → cycle N+1: res_valid=1, tag=3, taken=1, target=0x100, occupancy back to 0.
- Signed vs unsigned: Lt with 0xFFFF_FFFF vs 0x1 → taken=1; Ltu with the same operands → taken=0; Geu → 1; Dbr → 0.
- Wakeup ordering:
  - Dispatch A (tag 1, src1 waiting on tag 7), then B (tag 2, both ready).
  - B resolves first.
  - CDB tag 7 data 0x10 in cycle M → A resolves in M+1 with the correct compare.
- Age priority: fill DEPTH=4 with all sources waiting on tag 9. One CDB tag 9 broadcast → four consecutive res_valid pulses in dispatch order; disp_ready_out=0 while full and 1 after the first issue.
- Same-cycle bypass: dispatch with src2 tag 5 not ready while CDB broadcasts tag 5 = 0x20 → entry issues next cycle using 0x20.
- Flush/reset: three entries pending plus a ready candidate.
  - flush_in=1 → next cycle: occupancy=0, res_valid=0, no later resolves.
  - Repeat with rst_in=0 → res_* payloads also read 0.
